regfile: RTL
============

# regfile

General-purpose register file of the five-stage MIPS core: 32 × 32-bit registers with one write port driven by write-back and two asynchronous read ports serving the decode stage's operand fetch. Register 0 reads as zero and ignores writes. A same-cycle write→read bypass and a handshaked debug read port (for the bench/JTAG monitor) are included.

## Interface
- REG_NUM, 32, number of architectural registers
- REG_WIDTH, 32, register width (`RegBus`)
- ADDR_WIDTH, 5, register address width (`RegAddrBus`)

- clk  in  1  core clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-low
- we  in  1  write enable from write-back (`WriteEnable`)
- waddr  in  5  write address
- wdata  in  32  write data
- re1  in  1  read port 1 enable (`ReadEnable`)
- raddr1  in  5  read port 1 address
- rdata1  out  32  read port 1 data, combinational
- re2  in  1  read port 2 enable
- raddr2  in  5  read port 2 address
- rdata2  out  32  read port 2 data, combinational
- dbg_req  in  1  debug read request
- dbg_addr  in  5  debug read address, sampled with dbg_req
- dbg_ack  out  1  one-cycle pulse: dbg_data valid
- dbg_data  out  32  debug read data, registered

## Operation
- Write: at posedge, if we and waddr≠0, reg[waddr]←wdata. Writes to address 0 discarded.
- Read port k (combinational), priority order: rst asserted → 0; re_k deasserted → 0; raddr_k=0 → 0; bypass hit (see Configuration) → wdata; else reg[raddr_k].
- Ports fully independent; both may read the same address.
- Debug FSM, states IDLE, RESP:
  - IDLE: dbg_req=1 → latch dbg_addr, capture value (same priority as read ports, re treated as 1, bypass applied), go RESP.
  - RESP: dbg_ack=1 for exactly one cycle, dbg_data holds captured value; return IDLE unconditionally. dbg_req in RESP ignored (no queueing).
  - dbg_data holds last captured value until next capture.
- Reset (rst=0, any time, including mid-debug-transaction): all 31 registers ←0, FSM→IDLE, dbg_ack=0, dbg_data=0. Pending debug request is dropped without ack.

## Timing
- Reset values: rdata1=rdata2=0, dbg_ack=0, dbg_data=0, all registers 0.
- Write latency: data visible via array from cycle after write edge; via bypass in the same cycle.
- Read latency: 0 cycles (combinational from raddr/re/array).
- Debug latency: dbg_req sampled at edge N, dbg_ack high during cycle N+1, low at N+2; max throughput one read per 2 cycles.
- Simultaneous write and debug capture of same address: captured value is wdata (bypass) when bypass compiled in, old value otherwise.
- No combinational path from dbg_req to dbg_ack.

## Configuration
- `REGFILE_BYPASS_EN` defined: read/debug with re=1, raddr=waddr≠0, we=1 returns wdata in the same cycle (removes WB→ID hazard).
- Undefined: array value returned; write-back hazard must be covered by pipeline forwarding or stalls. Write behaviour unchanged.

## Structure
- Shared `define.v`: `RegBus`, `RegAddrBus`, `RegNum`, `ZeroWord`, `NOPRegAddr`, `ReadEnable/ReadDisable`, `WriteEnable/WriteDisable`, `RstEnable` (=1'b0), debug FSM state encodings.
- One sub-module: `regfile_dbg_port` (IDLE/RESP FSM + capture register), fed by a shared read-mux function.

## Test plan
- Reset: drive rst=0 mid-run after writing 0x1234_5678 to r5 → r5 reads 0, dbg_ack=0, dbg_data=0.
- Write/read: we=1, waddr=7, wdata=0xDEADBEEF; next cycle re1=1,raddr1=7 → rdata1=0xDEADBEEF; re1=0 → 0.
- Register 0: we=1, waddr=0, wdata=0xFFFFFFFF → rdata1/rdata2 at raddr 0 return 0.
- Bypass: same cycle we=1,waddr=3,wdata=0xA5A5A5A5 and raddr2=3,re2=1 (r3 old 0x11) → rdata2=0xA5A5A5A5 with `REGFILE_BYPASS_EN`, 0x11 without.
- Debug: r9=0x0000_0042, dbg_req=1,dbg_addr=9 one cycle → dbg_ack pulse next cycle, dbg_data=0x42; held dbg_req for 4 cycles → exactly 2 acks.
- Reset during RESP: assert rst while dbg_ack=1 → ack drops immediately, no ack after release.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants, FSM encoding and the read-mux function for the register file.
// Optional feature macro: REGFILE_BYPASS_EN (the same-cycle write->read bypass,
// used by rtl/regfile.sv).
package regfile_pkg;

  localparam int REG_NUM    = 32;
  localparam int REG_WIDTH  = 32;
  localparam int ADDR_WIDTH = 5;

  localparam logic [REG_WIDTH-1:0]  ZERO_WORD    = '0;
  localparam logic [ADDR_WIDTH-1:0] NOP_REG_ADDR = '0;
  localparam logic READ_ENABLE   = 1'b1;
  localparam logic READ_DISABLE  = 1'b0;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic RST_ENABLE    = 1'b0;

  typedef enum logic {
    DBG_IDLE = 1'b0,
    DBG_RESP = 1'b1
  } dbg_state_t;

  // Read priority shared by both operand ports and the debug capture:
  // reset, then disable, then r0, then bypass, then the array.
  function automatic logic [REG_WIDTH-1:0] rd_sel(
    input logic                  rst,
    input logic                  re,
    input logic [ADDR_WIDTH-1:0] raddr,
    input logic                  byp_hit,
    input logic [REG_WIDTH-1:0]  byp_data,
    input logic [REG_WIDTH-1:0]  arr_val
  );
    if (rst == RST_ENABLE)          return ZERO_WORD;
    else if (re == READ_DISABLE)    return ZERO_WORD;
    else if (raddr == NOP_REG_ADDR) return ZERO_WORD;
    else if (byp_hit)               return byp_data;
    else                            return arr_val;
  endfunction

endpackage

// File: rtl/regfile_dbg_port.sv
// Handshaked debug read port: IDLE/RESP FSM with a capture register.
// One request accepted every two cycles; requests seen in RESP are dropped.
module regfile_dbg_port
  import regfile_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dbg_req,
  input  logic [REG_WIDTH-1:0] cap_val,
  output logic                 dbg_ack,
  output logic [REG_WIDTH-1:0] dbg_data
);

  dbg_state_t state;

  // Capture on request in IDLE, pulse ack for one cycle in RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state    <= DBG_IDLE;
      dbg_ack  <= 1'b0;
      dbg_data <= ZERO_WORD;
    end else begin
      case (state)
        DBG_IDLE: begin
          if (dbg_req) begin
            dbg_data <= cap_val;
            dbg_ack  <= 1'b1;
            state    <= DBG_RESP;
          end else begin
            dbg_ack  <= 1'b0;
          end
        end
        DBG_RESP: begin
          dbg_ack <= 1'b0;
          state   <= DBG_IDLE;
        end
        default: begin
          dbg_ack <= 1'b0;
          state   <= DBG_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/regfile.sv
// 32x32 MIPS register file: one write port, two combinational read ports,
// and a handshaked debug read port. r0 reads zero and ignores writes.
// Optional feature macro: REGFILE_BYPASS_EN -- a read of the address being
// written this cycle returns wdata instead of the stale array value.
module regfile
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [REG_WIDTH-1:0]  wdata,
  input  logic                  re1,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  output logic [REG_WIDTH-1:0]  rdata1,
  input  logic                  re2,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [REG_WIDTH-1:0]  rdata2,
  input  logic                  dbg_req,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic                  dbg_ack,
  output logic [REG_WIDTH-1:0]  dbg_data
);

  logic [REG_NUM-1:0][REG_WIDTH-1:0] regs;
  logic                              hit1, hit2, hit_d;
  logic [REG_WIDTH-1:0]              dbg_val;

  // Write-back port; entry 0 is never written so it stays zero.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      regs <= '0;
    end else if (we == WRITE_ENABLE && waddr != NOP_REG_ADDR) begin
      regs[waddr] <= wdata;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign hit1  = (we == WRITE_ENABLE) && (waddr == raddr1);
  assign hit2  = (we == WRITE_ENABLE) && (waddr == raddr2);
  assign hit_d = (we == WRITE_ENABLE) && (waddr == dbg_addr);
`else
  assign hit1  = 1'b0;
  assign hit2  = 1'b0;
  assign hit_d = 1'b0;
`endif

  assign rdata1  = rd_sel(rst, re1, raddr1, hit1, wdata, regs[raddr1]);
  assign rdata2  = rd_sel(rst, re2, raddr2, hit2, wdata, regs[raddr2]);
  // Debug capture reads like an always-enabled port.
  assign dbg_val = rd_sel(rst, READ_ENABLE, dbg_addr, hit_d, wdata, regs[dbg_addr]);

  regfile_dbg_port u_dbg (
    .clk      (clk),
    .rst      (rst),
    .dbg_req  (dbg_req),
    .cap_val  (dbg_val),
    .dbg_ack  (dbg_ack),
    .dbg_data (dbg_data)
  );

endmodule
